// File: rtl/ll_monitor_if.sv
// LL/SC monitor bus: per-lane memory ops, flush/eret, snoop, SC result and link state.
// master drives ops and observes results; slave is the monitor.
interface ll_monitor_if #(
  parameter int ISSUE_NUM  = 2,
  parameter int ADDR_WIDTH = 32
);
  logic                                 flush;
  logic                                 eret;
  logic [ISSUE_NUM-1:0]                 op_ll;
  logic [ISSUE_NUM-1:0]                 op_sc;
  logic [ISSUE_NUM-1:0]                 op_st;
  logic [ISSUE_NUM-1:0][ADDR_WIDTH-1:0] op_addr;
  logic                                 snoop_valid;
  logic [ADDR_WIDTH-1:0]                snoop_addr;
  logic [ISSUE_NUM-1:0]                 sc_ok;
  logic                                 link_valid;
  logic [ADDR_WIDTH-1:0]                link_addr;

  modport master (
    output flush, eret, op_ll, op_sc, op_st, op_addr,
    output snoop_valid, snoop_addr,
    input  sc_ok, link_valid, link_addr
  );

  modport slave (
    input  flush, eret, op_ll, op_sc, op_st, op_addr,
    input  snoop_valid, snoop_addr,
    output sc_ok, link_valid, link_addr
  );
endinterface

// File: rtl/ll_monitor.sv
// Multi-lane LL/SC reservation monitor: clk, rst (async high), bus (slave modport).
// Optional snoop clearing enabled by defining CPU_LLSC_SNOOP_EN.
module ll_monitor #(
  parameter int ISSUE_NUM    = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int GRANULE_BITS = 4,
  parameter int TIMEOUT      = 0
) (
  input  logic         clk,
  input  logic         rst,
  ll_monitor_if.slave  bus
);
  localparam int GW = ADDR_WIDTH - GRANULE_BITS;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic                 v_q, v_d;
  logic [GW-1:0]        a_q, a_d;
  logic [ISSUE_NUM-1:0] sc_ok;
  logic                 ll_any;
  logic                 expire;

  assign ll_any = |bus.op_ll;

  // Expiry counter only exists when a timeout is configured.
  if (TIMEOUT > 0) begin : g_to
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (bus.flush)
        cnt_d = '0;
      else if (ll_any)
        cnt_d = CW'(TIMEOUT);
      else if (v_q && cnt_q != '0)
        cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign expire = v_q && !ll_any && cnt_q == CW'(1);
  end else begin : g_no_to
    assign expire = 1'b0;
  end

  // Working copy walks lanes oldest-first so younger lanes
  // see the effect of older ones in the same cycle.
  always_comb begin
    v_d   = v_q;
    a_d   = a_q;
    sc_ok = '0;
`ifdef CPU_LLSC_SNOOP_EN
    if (bus.snoop_valid && v_d &&
        bus.snoop_addr[ADDR_WIDTH-1:GRANULE_BITS] == a_d)
      v_d = 1'b0;
`endif
    for (int i = 0; i < ISSUE_NUM; i++) begin
      unique case (1'b1)
        bus.op_ll[i]: begin
          v_d = 1'b1;
          a_d = bus.op_addr[i][ADDR_WIDTH-1:GRANULE_BITS];
        end
        bus.op_sc[i]: begin
          sc_ok[i] = v_d &&
            bus.op_addr[i][ADDR_WIDTH-1:GRANULE_BITS] == a_d;
          v_d = 1'b0;
        end
        bus.op_st[i]: begin
          if (v_d &&
              bus.op_addr[i][ADDR_WIDTH-1:GRANULE_BITS] == a_d)
            v_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (bus.eret) v_d = 1'b0;
    if (expire)   v_d = 1'b0;
    if (bus.flush) begin
      v_d   = 1'b0;
      sc_ok = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      a_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
    end
  end

  assign bus.sc_ok      = sc_ok;
  assign bus.link_valid = v_q;
  assign bus.link_addr  = {a_q, {GRANULE_BITS{1'b0}}};

  // Offset bits inside a granule never take part in a match.
  logic [ISSUE_NUM-1:0] unused_lo;
  for (genvar g = 0; g < ISSUE_NUM; g++) begin : g_lane
    assign unused_lo[g] = ^bus.op_addr[g][GRANULE_BITS-1:0];
    a_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({bus.op_ll[g], bus.op_sc[g], bus.op_st[g]}));
  end

`ifdef CPU_LLSC_SNOOP_EN
  logic unused_snoop;
  assign unused_snoop = ^bus.snoop_addr[GRANULE_BITS-1:0];
`else
  logic unused_snoop;
  assign unused_snoop = ^{bus.snoop_valid, bus.snoop_addr};
`endif
endmodule

// File: tb/tb_ll_monitor.sv
// Scoreboard bench for ll_monitor: u0 has no timeout, u4 has TIMEOUT=4.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_ll_monitor;
`ifdef CPU_LLSC_SNOOP_EN
  localparam bit SNP = 1'b1;
`else
  localparam bit SNP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  always #5 clk = ~clk;

  ll_monitor_if #(.ISSUE_NUM(2), .ADDR_WIDTH(32)) i0 ();
  ll_monitor_if #(.ISSUE_NUM(2), .ADDR_WIDTH(32)) i4 ();

  ll_monitor #(.ISSUE_NUM(2), .ADDR_WIDTH(32),
               .GRANULE_BITS(4), .TIMEOUT(0))
    u0 (.clk(clk), .rst(rst), .bus(i0));

  ll_monitor #(.ISSUE_NUM(2), .ADDR_WIDTH(32),
               .GRANULE_BITS(4), .TIMEOUT(4))
    u4 (.clk(clk), .rst(rst), .bus(i4));

  typedef struct {
    bit          sel;
    logic [1:0]  sc;
    bit          lv;
    logic [31:0] la;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic idle_both();
    i0.flush = 0; i0.eret = 0; i0.op_ll = 0; i0.op_sc = 0;
    i0.op_st = 0; i0.op_addr = '0; i0.snoop_valid = 0;
    i0.snoop_addr = 0;
    i4.flush = 0; i4.eret = 0; i4.op_ll = 0; i4.op_sc = 0;
    i4.op_st = 0; i4.op_addr = '0; i4.snoop_valid = 0;
    i4.snoop_addr = 0;
  endtask

  task automatic step(
    input bit sel, input bit r,
    input logic [1:0] ll, input logic [1:0] sc,
    input logic [1:0] st,
    input logic [31:0] a0, input logic [31:0] a1,
    input bit fl, input bit er, input bit snv,
    input logic [31:0] sna,
    input logic [1:0] esc, input bit elv,
    input logic [31:0] ela);
    exp_t e;
    @(posedge clk); #1;
    idle_both();
    rst = r;
    if (sel) begin
      i4.op_ll = ll; i4.op_sc = sc; i4.op_st = st;
      i4.op_addr[0] = a0; i4.op_addr[1] = a1;
      i4.flush = fl; i4.eret = er;
      i4.snoop_valid = snv; i4.snoop_addr = sna;
    end else begin
      i0.op_ll = ll; i0.op_sc = sc; i0.op_st = st;
      i0.op_addr[0] = a0; i0.op_addr[1] = a1;
      i0.flush = fl; i0.eret = er;
      i0.snoop_valid = snv; i0.snoop_addr = sna;
    end
    e.sel = sel; e.sc = esc; e.lv = elv; e.la = ela;
    q.push_back(e);
    chk = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_empty: no expectation queued");
      end else begin
        exp_t e;
        logic [1:0]  a_sc;
        logic        a_lv;
        logic [31:0] a_la;
        e = q.pop_front();
        a_sc = e.sel ? i4.sc_ok      : i0.sc_ok;
        a_lv = e.sel ? i4.link_valid : i0.link_valid;
        a_la = e.sel ? i4.link_addr  : i0.link_addr;
        tests++;
        if (a_sc !== e.sc) begin
          fails++;
          $display("FAIL sc_ok u%0d t=%0t: got %b want %b",
                   e.sel ? 4 : 0, $time, a_sc, e.sc);
        end
        tests++;
        if (a_lv !== e.lv) begin
          fails++;
          $display("FAIL link_valid u%0d t=%0t: got %b want %b",
                   e.sel ? 4 : 0, $time, a_lv, e.lv);
        end
        if (e.lv) begin
          tests++;
          if (a_la !== e.la) begin
            fails++;
            $display("FAIL link_addr u%0d t=%0t: got %h want %h",
                     e.sel ? 4 : 0, $time, a_la, e.la);
          end
        end
      end
    end
  end

  initial begin
    idle_both();
    repeat (2) @(posedge clk);
    // SC while in reset, then after release
    step(0,1, 0,1,0, 'h1000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,1,0, 'h1000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,0,0, 0,0,      0,0,0,0, 2'b00,0,0);
    // LL lane 0, SC lane 1 same granule next cycle
    step(0,0, 1,0,0, 'h1004,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,2,0, 0,'h1008, 0,0,0,0, 2'b10,1,'h1000);
    step(0,0, 0,2,0, 0,'h1008, 0,0,0,0, 2'b00,0,0);
    // non-matching store keeps link
    step(0,0, 1,0,0, 'h2000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,0,1, 'h2010,0, 0,0,0,0, 2'b00,1,'h2000);
    step(0,0, 0,1,0, 'h2000,0, 0,0,0,0, 2'b01,1,'h2000);
    // matching store kills link
    step(0,0, 1,0,0, 'h2000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,0,1, 'h200C,0, 0,0,0,0, 2'b00,1,'h2000);
    step(0,0, 0,1,0, 'h2000,0, 0,0,0,0, 2'b00,0,0);
    // snoop to the linked granule
    step(0,0, 1,0,0, 'h3000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,0,0, 0,0, 0,0,1,'h3008, 2'b00,1,'h3000);
    step(0,0, 0,1,0, 'h3000,0, 0,0,0,0,
         SNP ? 2'b00 : 2'b01, !SNP,'h3000);
    step(0,0, 0,0,0, 0,0,      0,0,0,0, 2'b00,0,0);
    // flush dominates same-cycle LL+SC
    step(0,0, 1,2,0, 'h5000,'h5004, 1,0,0,0, 2'b00,0,0);
    step(0,0, 0,0,0, 0,0,      0,0,0,0, 2'b00,0,0);
    // eret: SC still passes, link cleared
    step(0,0, 1,2,0, 'h5000,'h5004, 0,1,0,0, 2'b10,0,0);
    step(0,0, 0,0,0, 0,0,      0,0,0,0, 2'b00,0,0);
    // SC lane 0 on old link, LL lane 1 new link
    step(0,0, 1,0,0, 'h7000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 2,1,0, 'h7000,'h8000, 0,0,0,0, 2'b01,1,'h7000);
    step(0,0, 0,0,0, 0,0,      0,0,0,0, 2'b00,1,'h8000);
    // snoop + LL same granule: LL wins
    step(0,0, 1,0,0, 'h8000,0, 0,0,1,'h8000, 2'b00,1,'h8000);
    step(0,0, 0,1,0, 'h8000,0, 0,0,0,0, 2'b01,1,'h8000);
    // reset mid-reservation
    step(0,0, 1,0,0, 'h9000,0, 0,0,0,0, 2'b00,0,0);
    step(0,0, 0,0,0, 0,0,      0,0,0,0, 2'b00,1,'h9000);
    step(0,1, 0,0,0, 0,0,      0,0,0,0, 2'b00,0,0);
    step(0,0, 0,1,0, 'h9000,0, 0,0,0,0, 2'b00,0,0);
    // TIMEOUT=4: three idle cycles, SC passes
    step(1,0, 1,0,0, 'h4000,0, 0,0,0,0, 2'b00,0,0);
    for (int k = 0; k < 3; k++)
      step(1,0, 0,0,0, 0,0, 0,0,0,0, 2'b00,1,'h4000);
    step(1,0, 0,1,0, 'h4000,0, 0,0,0,0, 2'b01,1,'h4000);
    // four idle cycles: expired
    step(1,0, 1,0,0, 'h4000,0, 0,0,0,0, 2'b00,0,0);
    for (int k = 0; k < 4; k++)
      step(1,0, 0,0,0, 0,0, 0,0,0,0, 2'b00,1,'h4000);
    step(1,0, 0,1,0, 'h4000,0, 0,0,0,0, 2'b00,0,0);
    // LL re-issued restarts the count
    step(1,0, 1,0,0, 'h4000,0, 0,0,0,0, 2'b00,0,0);
    for (int k = 0; k < 2; k++)
      step(1,0, 0,0,0, 0,0, 0,0,0,0, 2'b00,1,'h4000);
    step(1,0, 1,0,0, 'h4000,0, 0,0,0,0, 2'b00,1,'h4000);
    for (int k = 0; k < 3; k++)
      step(1,0, 0,0,0, 0,0, 0,0,0,0, 2'b00,1,'h4000);
    step(1,0, 0,1,0, 'h4000,0, 0,0,0,0, 2'b01,1,'h4000);

    @(posedge clk); #1;
    chk = 1'b0;
    idle_both();
    for (int k = 0; k < 10 && q.size() != 0; k++)
      @(posedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL sb_drain: %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
